// File: rtl/vsx_pkg.sv
// ---------------------------------------------------------------------------
// vsx_pkg
// Shared definitions for the vector/scalar operand bridge:
//   - starve_state_t : encoding of the starvation FSM states
//   - min1_clog2     : ceil(log2(n)), but never less than 1, for index widths
//   - id_width       : requester-id width for a given requester count
//   - count_width    : occupancy-counter width for a given queue depth
//   - starve_width   : blocked-cycle counter width for a given limit
// The response entry layout ({id, data}) depends on module parameters, so
// the packed struct for it is declared inside the top module.
// ---------------------------------------------------------------------------
package vsx_pkg;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,   // normal opportunistic operation
      ST_WAIT = 1'b1    // starving: asking the control unit to lend the port
   } starve_state_t;

   function automatic int min1_clog2(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int id_width(input int num_req);
      return min1_clog2(num_req);
   endfunction

   // One extra bit so a completely full queue can be represented.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // The counter only needs to reach STARVE_LIMIT-1.
   function automatic int starve_width(input int limit);
      return min1_clog2(limit);
   endfunction

endpackage

// File: rtl/vsx_resp_fifo.sv
// ---------------------------------------------------------------------------
// vsx_resp_fifo
// Synchronous FIFO holding bridge responses until the consumer takes them.
// The head entry is visible combinationally on pop_data.
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-high (empties the queue)
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry
//   pop        in   drop the head entry (ignored when empty)
//   pop_data   out  head entry (undefined contents when empty)
//   full       out  DEPTH entries stored
//   empty      out  no entries stored
//   count      out  occupancy, 0..DEPTH
// A push while full is accepted only together with a pop in the same cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module vsx_resp_fifo
   import vsx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = min1_clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; validity is tracked
   // by count/pointers alone, and resetting it would cost a reset net per bit.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/vec_scalar_operand_bridge.sv
// ---------------------------------------------------------------------------
// vec_scalar_operand_bridge
// Lets NUM_REQ vector requesters read scalar registers through regfile read
// port 1. The port is used whenever the scalar RR stage leaves it free; a
// requester blocked for STARVE_LIMIT cycles makes the bridge ask the control
// unit to stall RR and lend the port. Read data is bypassed from the same-cycle
// writeback and x0 always reads as zero. Results go through a small response
// queue with a valid/ready interface.
// Ports:
//   clk_i         in   clock
//   rst_i         in   synchronous reset, active-high
//   req_valid_i   in   per-requester read request
//   req_addr_i    in   packed indices, requester k at [k*ADDR_W +: ADDR_W]
//   req_ready_o   out  one-hot grant (zero when nothing is accepted)
//   port_free_i   in   scalar pipeline leaves read port 1 idle this cycle
//   steal_ack_i   in   control unit stalled RR, port reserved this cycle
//   steal_req_o   out  request to stall RR and lend read port 1
//   rf_rd_en_o    out  bridge drives read port 1 this cycle
//   rf_rd_addr_o  out  read index (zero when not driving the port)
//   rf_rd_data_i  in   combinational regfile read data
//   wb_en_i       in   regfile write this cycle
//   wb_addr_i     in   write index
//   wb_data_i     in   write data
//   resp_valid_o  out  response queue not empty
//   resp_ready_i  in   consumer pops the head
//   resp_data_o   out  head data (zero when empty)
//   resp_id_o     out  head requester id (zero when empty)
//   count_o       out  queue occupancy
// ---------------------------------------------------------------------------
module vec_scalar_operand_bridge
   import vsx_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int XLEN         = 64,
   parameter int ADDR_W       = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int ID_W         = id_width(NUM_REQ),
   parameter int CNT_W        = count_width(FIFO_DEPTH)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic                      port_free_i,
   input  logic                      steal_ack_i,
   output logic                      steal_req_o,
   output logic                      rf_rd_en_o,
   output logic [ADDR_W-1:0]         rf_rd_addr_o,
   input  logic [XLEN-1:0]           rf_rd_data_i,
   input  logic                      wb_en_i,
   input  logic [ADDR_W-1:0]         wb_addr_i,
   input  logic [XLEN-1:0]           wb_data_i,
   output logic                      resp_valid_o,
   input  logic                      resp_ready_i,
   output logic [XLEN-1:0]           resp_data_o,
   output logic [ID_W-1:0]           resp_id_o,
   output logic [CNT_W-1:0]          count_o
);

   localparam int SC_W = starve_width(STARVE_LIMIT);

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [XLEN-1:0] data;
   } resp_t;

   // Arbiter
   logic [ID_W-1:0]    rr_ptr;
   logic [ID_W-1:0]    grant_idx;
   logic [NUM_REQ-1:0] pick;
   logic [ADDR_W-1:0]  grant_addr;
   logic               found;
   logic               avail;
   logic               space;
   logic               accept;
   logic               any_valid;
   int                 scan_pos;
   logic [ID_W-1:0]    scan_idx;

   // Data path
   logic [XLEN-1:0]    sel_data;
   resp_t              push_entry;
   resp_t              head_entry;
   logic               fifo_full;
   logic               fifo_empty;

   // Starvation FSM
   starve_state_t      state;
   starve_state_t      next_state;
   logic [SC_W-1:0]    starve_cnt;
   logic [SC_W-1:0]    next_cnt;
   logic               blocked;

   assign any_valid = |req_valid_i;
   assign avail     = port_free_i | steal_ack_i;
   // A pop in the same cycle frees a slot for the push even when full.
   assign space     = ~fifo_full | (resp_valid_o & resp_ready_i);

   // -----------------------------------------------------------------------
   // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
   // -----------------------------------------------------------------------
   // NOTE: every variable written in a combinational block gets a default
   // first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      found      = 1'b0;
      pick       = '0;
      grant_idx  = '0;
      grant_addr = '0;
      scan_pos   = 0;
      scan_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_pos = int'(rr_ptr) + i;
         if (scan_pos >= NUM_REQ) scan_pos = scan_pos - NUM_REQ;
         scan_idx = scan_pos[ID_W-1:0];
         if (!found && req_valid_i[scan_idx]) begin
            found           = 1'b1;
            pick[scan_idx]  = 1'b1;
            grant_idx       = scan_idx;
            grant_addr      = req_addr_i[scan_pos*ADDR_W +: ADDR_W];
         end
      end
   end

   assign accept       = found & avail & space;
   assign req_ready_o  = accept ? pick : '0;
   assign rf_rd_en_o   = accept;
   assign rf_rd_addr_o = accept ? grant_addr : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (accept) begin
         if (grant_idx == ID_W'(NUM_REQ - 1)) rr_ptr <= '0;
         else                                 rr_ptr <= grant_idx + 1'b1;
      end
   end

   // -----------------------------------------------------------------------
   // Operand select: x0 is hard zero and outranks a (meaningless) write to
   // x0; otherwise a same-cycle writeback to the same index wins over the
   // stale regfile contents.
   // -----------------------------------------------------------------------
   always_comb begin
      if (grant_addr == '0)
         sel_data = '0;
      else if (wb_en_i && (wb_addr_i == grant_addr))
         sel_data = wb_data_i;
      else
         sel_data = rf_rd_data_i;
   end

   always_comb begin
      push_entry.id   = grant_idx;
      push_entry.data = sel_data;
   end

   vsx_resp_fifo #(
      .WIDTH (XLEN + ID_W),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_resp_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (accept),
      .push_data (push_entry),
      .pop       (resp_ready_i),
      .pop_data  (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (count_o)
   );

   // Stale storage is never exposed: an empty queue presents zeros.
   assign resp_valid_o = ~fifo_empty;
   assign resp_data_o  = fifo_empty ? '0 : head_entry.data;
   assign resp_id_o    = fifo_empty ? '0 : head_entry.id;

   // -----------------------------------------------------------------------
   // Starvation FSM
   // -----------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= ST_RUN;
         starve_cnt <= '0;
      end else begin
         state      <= next_state;
         starve_cnt <= next_cnt;
      end
   end

   assign blocked = any_valid & ~accept;

   always_comb begin
      next_state = state;
      next_cnt   = starve_cnt;
      case (state)
         ST_RUN: begin
            if (accept) begin
               next_cnt = '0;
            end else if (blocked) begin
               if (starve_cnt == SC_W'(STARVE_LIMIT - 1)) next_state = ST_WAIT;
               else                                       next_cnt   = starve_cnt + 1'b1;
            end
         end
         ST_WAIT: begin
            // Leave on: any grant (normally via steal_ack), requests gone,
            // or a full queue, where lending the port would not help.
            if (accept || !any_valid || (blocked && !space)) begin
               next_state = ST_RUN;
               next_cnt   = '0;
            end
         end
         default: begin
            next_state = ST_RUN;
            next_cnt   = '0;
         end
      endcase
   end

   // Decoded straight from the state flop, so the request is glitch-free.
   always_comb begin
      steal_req_o = (state == ST_WAIT);
   end

endmodule
